// File: rtl/sr_latch_bank.sv
// sr_latch_bank: bank of WIDTH independent, clock-edge SR storage channels.
// Each channel has its own set, reset and enable. MODE fixes how S=R=1 is resolved.
// The bank also reports change pulses, sticky conflict flags and a saturating
// conflict-cycle counter. Every output comes from a register.
module sr_latch_bank #(
    parameter int                 WIDTH   = 8,
    parameter int                 MODE    = 0,
    parameter logic [WIDTH-1:0]   RST_VAL = '0,
    parameter int                 CNT_W   = 4
) (
    input  logic             in_CLK,
    input  logic             in_RST_N,
    input  logic [WIDTH-1:0] in_S,
    input  logic [WIDTH-1:0] in_R,
    input  logic [WIDTH-1:0] in_EN,
    input  logic             in_CLR_ERR,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] data_out_n,
    output logic [WIDTH-1:0] chg_out,
    output logic [WIDTH-1:0] err_out,
    output logic [CNT_W-1:0] err_cnt_out
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] s_eff;
    logic [WIDTH-1:0] r_eff;
    logic [WIDTH-1:0] conf;

    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] chg_q,  chg_d;
    logic [WIDTH-1:0] err_q,  err_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic [CNT_W-1:0] cnt_base;

    // Resolves an enabled S=R=1 request. Unknown MODE values fall back to hold.
    function automatic logic resolve_conflict(input logic q);
        case (MODE)
            1:       resolve_conflict = 1'b1;
            2:       resolve_conflict = 1'b0;
            3:       resolve_conflict = ~q;
            default: resolve_conflict = q;
        endcase
    endfunction

    // Next-state logic for the channel values, change pulses, flags and counter.
    always_comb begin
        s_eff  = in_S & in_EN;
        r_eff  = in_R & in_EN;
        conf   = s_eff & r_eff;
        data_d = data_q;
        for (int i = 0; i < WIDTH; i++) begin
            case ({s_eff[i], r_eff[i]})
                2'b10:   data_d[i] = 1'b1;
                2'b01:   data_d[i] = 1'b0;
                2'b11:   data_d[i] = resolve_conflict(data_q[i]);
                default: data_d[i] = data_q[i];
            endcase
        end
        chg_d = data_d ^ data_q;

        // A conflict in the same cycle as a clear is still recorded.
        err_d    = (in_CLR_ERR ? '0 : err_q) | conf;
        cnt_base = in_CLR_ERR ? '0 : cnt_q;
        cnt_d    = cnt_base;
        if ((|conf) && (cnt_base != CNT_MAX)) begin
            cnt_d = cnt_base + CNT_W'(1);
        end
    end

    // State registers. Reset is asynchronous, so there is no change pulse for the reset transition.
    always_ff @(posedge in_CLK or negedge in_RST_N) begin
        if (!in_RST_N) begin
            data_q <= RST_VAL;
            chg_q  <= '0;
            err_q  <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            chg_q  <= chg_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
        end
    end

    assign data_out    = data_q;
    assign data_out_n  = ~data_q;
    assign chg_out     = chg_q;
    assign err_out     = err_q;
    assign err_cnt_out = cnt_q;

endmodule

// File: tb/tb_sr_latch_bank.sv
// Directed testbench for sr_latch_bank.
// It instantiates four banks that differ only in MODE (0..3), plus one extra
// MODE-0 bank with CNT_W=2 for the counter saturation test.
module tb_sr_latch_bank;

    localparam logic [7:0] RV = 8'hA5;

    logic       clk;
    logic       rst_n;
    logic [7:0] s, r, en;
    logic       clr;

    logic [7:0] d_out [4];
    logic [7:0] d_n   [4];
    logic [7:0] chg   [4];
    logic [7:0] err   [4];
    logic [3:0] cnt   [4];

    logic [7:0] c_d, c_dn, c_chg, c_err;
    logic [1:0] c_cnt;

    int errors = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sr_latch_bank #(.WIDTH(8), .MODE(g), .RST_VAL(RV), .CNT_W(4)) u_dut (
            .in_CLK(clk), .in_RST_N(rst_n), .in_S(s), .in_R(r), .in_EN(en),
            .in_CLR_ERR(clr), .data_out(d_out[g]), .data_out_n(d_n[g]),
            .chg_out(chg[g]), .err_out(err[g]), .err_cnt_out(cnt[g])
        );
    end

    sr_latch_bank #(.WIDTH(8), .MODE(0), .RST_VAL(RV), .CNT_W(2)) u_cnt2 (
        .in_CLK(clk), .in_RST_N(rst_n), .in_S(s), .in_R(r), .in_EN(en),
        .in_CLR_ERR(clr), .data_out(c_d), .data_out_n(c_dn),
        .chg_out(c_chg), .err_out(c_err), .err_cnt_out(c_cnt)
    );

    // Advance one rising edge and settle 1 ns past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] s_v, input logic [7:0] r_v,
                         input logic [7:0] en_v, input logic clr_v);
        s = s_v; r = r_v; en = en_v; clr = clr_v;
    endtask

    task automatic do_reset();
        drive(8'h00, 8'h00, 8'h00, 1'b0);
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        drive(8'h00, 8'h00, 8'h00, 1'b0);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (d_out[k] !== RV || d_n[k] !== 8'h5A || chg[k] !== 8'h00 ||
                err[k] !== 8'h00 || cnt[k] !== 4'd0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got d=%h n=%h chg=%h err=%h cnt=%0d, want d=a5 n=5a chg=0 err=0 cnt=0",
                         k, d_out[k], d_n[k], chg[k], err[k], cnt[k]);
            end
        end
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (d_out[k] !== RV || d_n[k] !== 8'h5A || chg[k] !== 8'h00 ||
                err[k] !== 8'h00 || cnt[k] !== 4'd0) begin
                errors++;
                $display("FAIL reset_release[%0d]: got d=%h n=%h chg=%h err=%h cnt=%0d, want d=a5 n=5a chg=0 err=0 cnt=0",
                         k, d_out[k], d_n[k], chg[k], err[k], cnt[k]);
            end
        end
        // Disturb the state, then assert reset between clock edges.
        drive(8'hFF, 8'h00, 8'hFF, 1'b0);
        tick();
        checks++;
        if (d_out[0] !== 8'hFF || chg[0] !== 8'h5A) begin
            errors++;
            $display("FAIL set_all: got d=%h chg=%h, want d=ff chg=5a", d_out[0], chg[0]);
        end
        drive(8'hFF, 8'hFF, 8'hFF, 1'b0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (d_out[1] !== RV || d_n[1] !== 8'h5A || chg[1] !== 8'h00 ||
            err[1] !== 8'h00 || cnt[1] !== 4'd0) begin
            errors++;
            $display("FAIL reset_async: got d=%h n=%h chg=%h err=%h cnt=%0d, want d=a5 n=5a chg=0 err=0 cnt=0",
                     d_out[1], d_n[1], chg[1], err[1], cnt[1]);
        end
        drive(8'h00, 8'h00, 8'h00, 1'b0);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_enable();
        do_reset();
        drive(8'h00, 8'hFF, 8'hFF, 1'b0);
        tick();
        checks++;
        if (d_out[0] !== 8'h00 || d_n[0] !== 8'hFF || chg[0] !== 8'hA5) begin
            errors++;
            $display("FAIL clear_all: got d=%h n=%h chg=%h, want d=00 n=ff chg=a5", d_out[0], d_n[0], chg[0]);
        end
        drive(8'hFF, 8'h00, 8'h0F, 1'b0);
        tick();
        checks++;
        if (d_out[0] !== 8'h0F || chg[0] !== 8'h0F || d_n[0] !== 8'hF0) begin
            errors++;
            $display("FAIL en_set: got d=%h n=%h chg=%h, want d=0f n=f0 chg=0f", d_out[0], d_n[0], chg[0]);
        end
        drive(8'h00, 8'h00, 8'h00, 1'b0);
        tick();
        checks++;
        if (d_out[0] !== 8'h0F || chg[0] !== 8'h00) begin
            errors++;
            $display("FAIL en_hold: got d=%h chg=%h, want d=0f chg=00", d_out[0], chg[0]);
        end
        drive(8'h00, 8'h03, 8'h0F, 1'b0);
        tick();
        checks++;
        if (d_out[0] !== 8'h0C || chg[0] !== 8'h03 || err[0] !== 8'h00) begin
            errors++;
            $display("FAIL en_reset: got d=%h chg=%h err=%h, want d=0c chg=03 err=00", d_out[0], chg[0], err[0]);
        end
    endtask

    task automatic test_mode_sweep();
        logic [7:0] exp_d [4];
        logic [7:0] exp_c [4];
        exp_d[0] = 8'h0F; exp_d[1] = 8'hFF; exp_d[2] = 8'h00; exp_d[3] = 8'hF0;
        exp_c[0] = 8'h00; exp_c[1] = 8'hF0; exp_c[2] = 8'h0F; exp_c[3] = 8'hFF;
        do_reset();
        drive(8'h0F, 8'hF0, 8'hFF, 1'b0);
        tick();
        drive(8'hFF, 8'hFF, 8'hFF, 1'b0);
        tick();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (d_out[k] !== exp_d[k] || d_n[k] !== ~exp_d[k] || chg[k] !== exp_c[k] ||
                err[k] !== 8'hFF || cnt[k] !== 4'd1) begin
                errors++;
                $display("FAIL mode_sweep[%0d]: got d=%h n=%h chg=%h err=%h cnt=%0d, want d=%h n=%h chg=%h err=ff cnt=1",
                         k, d_out[k], d_n[k], chg[k], err[k], cnt[k], exp_d[k], ~exp_d[k], exp_c[k]);
            end
        end
    endtask

    task automatic test_toggle();
        logic [4:0] seq;
        seq = 5'b10101;
        do_reset();
        drive(8'h00, 8'hFF, 8'hFF, 1'b0);
        tick();
        drive(8'h01, 8'h01, 8'h01, 1'b0);
        for (int n = 0; n < 5; n++) begin
            tick();
            checks++;
            if (d_out[3] !== {7'b0, seq[4-n]} || chg[3] !== 8'h01) begin
                errors++;
                $display("FAIL toggle[%0d]: got d=%h chg=%h, want d=%h chg=01",
                         n, d_out[3], chg[3], {7'b0, seq[4-n]});
            end
        end
        checks++;
        if (d_out[0] !== 8'h00 || chg[0] !== 8'h00 || cnt[0] !== 4'd5) begin
            errors++;
            $display("FAIL toggle_mode0_hold: got d=%h chg=%h cnt=%0d, want d=00 chg=00 cnt=5",
                     d_out[0], chg[0], cnt[0]);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_c2 [5];
        exp_c2[0] = 2'd1; exp_c2[1] = 2'd2; exp_c2[2] = 2'd3; exp_c2[3] = 2'd3; exp_c2[4] = 2'd3;
        do_reset();
        drive(8'h01, 8'h01, 8'h01, 1'b0);
        for (int n = 0; n < 5; n++) begin
            tick();
            checks++;
            if (c_cnt !== exp_c2[n] || cnt[0] !== 4'(n + 1) || c_err !== 8'h01) begin
                errors++;
                $display("FAIL sat[%0d]: got cnt2=%0d cnt4=%0d err=%h, want cnt2=%0d cnt4=%0d err=01",
                         n, c_cnt, cnt[0], c_err, exp_c2[n], n + 1);
            end
        end
        drive(8'h00, 8'h00, 8'h00, 1'b1);
        tick();
        checks++;
        if (c_cnt !== 2'd0 || c_err !== 8'h00 || cnt[0] !== 4'd0 || err[0] !== 8'h00) begin
            errors++;
            $display("FAIL sat_clear: got cnt2=%0d err2=%h cnt4=%0d err4=%h, want all 0",
                     c_cnt, c_err, cnt[0], err[0]);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(8'h10, 8'h10, 8'h10, 1'b0);
        tick();
        tick();
        drive(8'h00, 8'h00, 8'h00, 1'b0);
        tick();
        checks++;
        if (err[0] !== 8'h10 || cnt[0] !== 4'd2) begin
            errors++;
            $display("FAIL sticky: got err=%h cnt=%0d, want err=10 cnt=2", err[0], cnt[0]);
        end
        drive(8'h04, 8'h04, 8'h04, 1'b1);
        tick();
        checks++;
        if (err[0] !== 8'h04 || cnt[0] !== 4'd1 || d_out[0] !== RV) begin
            errors++;
            $display("FAIL clr_and_conflict: got err=%h cnt=%0d d=%h, want err=04 cnt=1 d=a5",
                     err[0], cnt[0], d_out[0]);
        end
        drive(8'h00, 8'h00, 8'h00, 1'b0);
    endtask

    initial begin
        rst_n = 1'b1;
        drive(8'h00, 8'h00, 8'h00, 1'b0);
        #2;
        test_reset();
        test_enable();
        test_mode_sweep();
        test_toggle();
        test_saturation();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
